// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and default widths shared by the ALU/MDU slice
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_OP_SZ = 4;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_ADDU  = 4'd1,
        OP_SUB   = 4'd2,
        OP_SUBU  = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_SLT   = 4'd8,
        OP_NOR   = 4'd9,
        OP_MULT  = 4'd10,
        OP_MULTU = 4'd11,
        OP_DIV   = 4'd12,
        OP_DIVU  = 4'd13,
        OP_MFHI  = 4'd14,
        OP_MFLO  = 4'd15
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    function automatic logic is_md_op(input opcode_t o);
        return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - one-bit-per-step unsigned shift-add multiplier / restoring divider
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] sreg,
    output logic             last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd;
    logic             div_mode;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_try;
    logic [WIDTH:0]   rem_diff;

    // Multiply keeps {acc,sreg} as the growing product shifted right;
    // divide shifts the dividend out of sreg into the partial remainder.
    always_comb begin
        add_sum  = {1'b0, acc} + {1'b0, opnd};
        rem_try  = {acc, sreg[WIDTH-1]};
        rem_diff = rem_try - {1'b0, opnd};
        last     = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            sreg     <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            cnt      <= '0;
        end else if (load) begin
            acc      <= '0;
            sreg     <= a_mag;
            opnd     <= b_mag;
            div_mode <= is_div;
            cnt      <= '0;
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (div_mode) begin
                if (!rem_diff[WIDTH]) begin
                    acc  <= rem_diff[WIDTH-1:0];
                    sreg <= {sreg[WIDTH-2:0], 1'b1};
                end else begin
                    acc  <= rem_try[WIDTH-1:0];
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                end
            end else if (sreg[0]) begin
                {acc, sreg} <= {add_sum, sreg[WIDTH-1:1]};
            end else begin
                {acc, sreg} <= {1'b0, acc, sreg[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_md.sv
// rtl/alu_md.sv - ALU with single-cycle ops and iterative mult/div writing HI/LO
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int OP_SZ = DEFAULT_OP_SZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_SZ-1:0] op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ovf,
    output logic             div_zero
);

    state_t           state;
    opcode_t          op_sel;
    logic             accept;
    logic             md_op;
    logic             div_op;
    logic             signed_op;
    logic             div_by_zero;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] sc_result;
    logic             sc_ovf;

    logic             md_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] mdu_acc;
    logic [WIDTH-1:0] mdu_sreg;
    logic             mdu_last;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign op_sel      = opcode_t'(op[3:0]);
    assign accept      = start && !busy && (state == S_IDLE);
    assign md_op       = is_md_op(op_sel);
    assign div_op      = (op_sel == OP_DIV) || (op_sel == OP_DIVU);
    assign signed_op   = (op_sel == OP_MULT) || (op_sel == OP_DIV);
    assign div_by_zero = div_op && (B == '0);
    assign sum         = A + B;
    assign dif         = A - B;
    assign a_mag       = (signed_op && A[WIDTH-1]) ? -A : A;
    assign b_mag       = (signed_op && B[WIDTH-1]) ? -B : B;

    always_comb begin
        sc_result = '0;
        sc_ovf    = 1'b0;
        case (op_sel)
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_ADDU: sc_result = sum;
            OP_SUB: begin
                sc_result = dif;
                sc_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUBU: sc_result = dif;
            OP_AND:  sc_result = A & B;
            OP_OR:   sc_result = A | B;
            OP_XOR:  sc_result = A ^ B;
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_NOR:  sc_result = ~(A | B);
            OP_MFHI: sc_result = hi;
            OP_MFLO: sc_result = lo;
            default: sc_result = '0;
        endcase
    end

    // Operands were turned into magnitudes at accept; the sign is restored here.
    always_comb begin
        prod_fix = neg_q ? -{mdu_acc, mdu_sreg} : {mdu_acc, mdu_sreg};
        quo_fix  = neg_q ? -mdu_sreg : mdu_sreg;
        rem_fix  = neg_r ? -mdu_acc : mdu_acc;
    end

    mdu_iter #(
        .WIDTH(WIDTH)
    ) u_mdu (
        .clk   (clk),
        .rst   (rst),
        .load  (accept && md_op && !div_by_zero),
        .step  ((state == S_LOAD) || (state == S_ITER)),
        .is_div(div_op),
        .a_mag (a_mag),
        .b_mag (b_mag),
        .acc   (mdu_acc),
        .sreg  (mdu_sreg),
        .last  (mdu_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            hi       <= '0;
            lo       <= '0;
            ovf      <= 1'b0;
            div_zero <= 1'b0;
            md_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        busy   <= 1'b1;
                        md_div <= div_op;
                        neg_q  <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r  <= signed_op && A[WIDTH-1];
                        if (md_op && !div_by_zero) begin
                            state <= S_LOAD;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            if (div_by_zero) begin
                                result   <= '1;
                                lo       <= '1;
                                hi       <= A;
                                ovf      <= 1'b0;
                                div_zero <= 1'b1;
                            end else begin
                                result   <= sc_result;
                                ovf      <= sc_ovf;
                                div_zero <= 1'b0;
                            end
                        end
                    end
                end
                S_LOAD: state <= S_ITER;
                S_ITER: begin
                    if (mdu_last) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state    <= S_DONE;
                    done     <= 1'b1;
                    ovf      <= 1'b0;
                    div_zero <= 1'b0;
                    if (md_div) begin
                        lo     <= quo_fix;
                        hi     <= rem_fix;
                        result <= quo_fix;
                    end else begin
                        hi     <= prod_fix[2*WIDTH-1:WIDTH];
                        lo     <= prod_fix[WIDTH-1:0];
                        result <= prod_fix[WIDTH-1:0];
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// tb/tb_alu_md.sv - scoreboard bench for alu_md against a native-arithmetic model
module tb_alu_md;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ovf;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
    logic        div_zero;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    alu_md #(
        .WIDTH(32),
        .OP_SZ(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .A       (a_in),
        .B       (b_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .hi      (hi),
        .lo      (lo),
        .ovf     (ovf),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb_v;
        longint      s;
        logic [63:0] p;
        sa    = longint'($signed(a));
        sb_v  = longint'($signed(b));
        e.tag = "";
        e.acc = 0;
        e.hi  = mhi;
        e.lo  = mlo;
        e.ovf = 1'b0;
        e.dz  = 1'b0;
        e.lat = 1;
        e.res = '0;
        case (o)
            4'd0: begin
                s = sa + sb_v;
                e.res = a + b;
                e.ovf = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
            end
            4'd1: e.res = a + b;
            4'd2: begin
                s = sa - sb_v;
                e.res = a - b;
                e.ovf = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
            end
            4'd3: e.res = a - b;
            4'd4: e.res = a & b;
            4'd5: e.res = a | b;
            4'd6: e.res = a ^ b;
            4'd7: e.res = (a < b) ? 32'd1 : 32'd0;
            4'd8: e.res = (sa < sb_v) ? 32'd1 : 32'd0;
            4'd9: e.res = ~(a | b);
            4'd10, 4'd11: begin
                if (o == 4'd10) p = 64'(sa * sb_v);
                else            p = {32'b0, a} * {32'b0, b};
                e.hi  = p[63:32];
                e.lo  = p[31:0];
                e.res = p[31:0];
                e.lat = 34;
            end
            4'd12, 4'd13: begin
                if (b == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                    e.dz = 1'b1;
                end else if (o == 4'd12) begin
                    p    = 64'(sa / sb_v);
                    e.lo = p[31:0];
                    p    = 64'(sa % sb_v);
                    e.hi = p[31:0];
                    e.lat = 34;
                end else begin
                    e.lo  = a / b;
                    e.hi  = a % b;
                    e.lat = 34;
                end
                e.res = e.lo;
            end
            4'd14: e.res = mhi;
            default: e.res = mlo;
        endcase
        return e;
    endfunction

    task automatic drive(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check_eq({tag, "_idle"}, 64'(busy), 64'(0));
        e = model(o, a, b);
        e.tag = tag;
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        e.acc = cyc;
        sb.push_back(e);
        if (o >= 4'd10 && o <= 4'd13) begin
            mhi = e.hi;
            mlo = e.lo;
        end
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check_eq("stray_done", 64'(done), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                check_eq({mon_e.tag, "_res"}, 64'(result), 64'(mon_e.res));
                check_eq({mon_e.tag, "_hi"}, 64'(hi), 64'(mon_e.hi));
                check_eq({mon_e.tag, "_lo"}, 64'(lo), 64'(mon_e.lo));
                check_eq({mon_e.tag, "_ovf"}, 64'(ovf), 64'(mon_e.ovf));
                check_eq({mon_e.tag, "_dz"}, 64'(div_zero), 64'(mon_e.dz));
                check_eq({mon_e.tag, "_lat"}, 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
            end
        end
    end

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        rst   = 1'b1;
        start = 1'b1;
        op    = 4'd0;
        a_in  = 32'd5;
        b_in  = 32'd6;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_result", 64'(result), 64'(0));
        check_eq("rst_hi", 64'(hi), 64'(0));
        check_eq("rst_lo", 64'(lo), 64'(0));
        check_eq("rst_flags", 64'({ovf, div_zero}), 64'(0));
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        drive("addu_wrap", 4'd1, 32'hFFFF_FFFF, 32'd1);
        drive("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1);
        drive("sub_ovf", 4'd2, 32'h8000_0000, 32'd1);
        drive("subu", 4'd3, 32'h8000_0000, 32'd1);
        drive("and", 4'd4, 32'hF0F0_1234, 32'h0FF0_FF00);
        drive("or", 4'd5, 32'hF0F0_1234, 32'h0FF0_FF00);
        drive("xor", 4'd6, 32'hF0F0_1234, 32'h0FF0_FF00);
        drive("nor", 4'd9, 32'hF0F0_1234, 32'h0FF0_FF00);
        drive("slt", 4'd8, 32'hFFFF_FFFF, 32'd1);
        drive("sltu", 4'd7, 32'hFFFF_FFFF, 32'd1);
        drive("mult_neg", 4'd10, 32'hFFFF_FFFD, 32'd7);
        drive("mfhi", 4'd14, 32'd0, 32'd0);
        drive("mflo", 4'd15, 32'd0, 32'd0);
        drive("multu_max", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drive("div_neg", 4'd12, 32'hFFFF_FFF9, 32'd2);
        drive("div_negb", 4'd12, 32'd7, 32'hFFFF_FFFE);
        drive("divu_zero", 4'd13, 32'd7, 32'd0);
        drive("add_clear", 4'd0, 32'd1, 32'd2);
        drive("div_zero_s", 4'd12, 32'h8000_0005, 32'd0);
        drive("div_min", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF);
        drive("mult_min", 4'd10, 32'h8000_0000, 32'h8000_0000);

        drive("divu_busy", 4'd13, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = 4'd0;
        a_in  = 32'd1;
        b_in  = 32'd2;
        @(negedge clk);
        start = 1'b0;

        drive("xor_done", 4'd6, 32'h1234_5678, 32'hFFFF_0000);
        start = 1'b1;
        op    = 4'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_eq("donecyc_busy", 64'(busy), 64'(0));
        check_eq("donecyc_done", 64'(done), 64'(0));

        for (int i = 0; i < 24; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom();
            rb = (i % 6 == 5) ? 32'd0 : $urandom();
            drive($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb);
        end

        drive("mult_abort", 4'd10, 32'd12345, 32'd678);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        mhi = '0;
        mlo = '0;
        check_eq("abort_busy", 64'(busy), 64'(0));
        check_eq("abort_done", 64'(done), 64'(0));
        check_eq("abort_hi", 64'(hi), 64'(0));
        check_eq("abort_lo", 64'(lo), 64'(0));
        repeat (40) @(negedge clk);
        drive("mfhi_after", 4'd14, 32'd0, 32'd0);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check_eq("drain", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
